// File: rtl/bus_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing the single MemoryUnit bus between CPU (m0) and DMA (m1).
// Define BUS_ARB_TIMEOUT_EN to add the issue watchdog, the DRAIN state and the sticky err_to flag.
module bus_arbiter #(
  parameter int                ADDR_W    = 27,
  parameter int                DATA_W    = 32,
  parameter int                TIMEOUT   = 1024,
  parameter logic [DATA_W-1:0] TIMEOUT_Q = DATA_W'(32'hDEADBEEF)
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_data,
  input  logic              m0_we,
  input  logic              m0_start,
  output logic [DATA_W-1:0] m0_q,
  output logic              m0_done,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_data,
  input  logic              m1_we,
  input  logic              m1_start,
  output logic [DATA_W-1:0] m1_q,
  output logic              m1_done,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_we,
  output logic              bus_start,
  input  logic [DATA_W-1:0] bus_q,
  input  logic              bus_done,
  output logic              busy,
  output logic              err_to
);

`ifdef BUS_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;
  // Forced completion lands on the master exactly TIMEOUT cycles after the bus_start cycle.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 2);
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
`else
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
`endif

  state_t              state_q, state_d;
  logic                last_q, last_d;
  logic                gnt_q, gnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;
  logic                m0_done_q, m0_done_d;
  logic                m1_done_q, m1_done_d;
  logic                sel;
  logic                fire;
  logic [DATA_W-1:0]   fire_val;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    we_d       = we_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    m0_done_d  = 1'b0;
    m1_done_d  = 1'b0;
    sel        = 1'b0;
    fire       = 1'b0;
    fire_val   = TIMEOUT_Q;
`ifdef BUS_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = err_q;
`endif
    case (state_q)
      IDLE: begin
        // A done pulse still on the outputs means the master has not yet dropped start.
        if ((m0_start || m1_start) && !(m0_done_q || m1_done_q)) begin
          sel     = (m0_start && m1_start) ? ~last_q : m1_start;
          gnt_d   = sel;
          last_d  = sel;
          addr_d  = sel ? m1_addr : m0_addr;
          data_d  = sel ? m1_data : m0_data;
          we_d    = sel ? m1_we   : m0_we;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef BUS_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        if (bus_done) begin
          fire     = 1'b1;
          fire_val = bus_q;
          state_d  = IDLE;
        end
`ifdef BUS_ARB_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          fire    = 1'b1;
          err_d   = 1'b1;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
`ifdef BUS_ARB_TIMEOUT_EN
      DRAIN: begin
        // The late slave completion is swallowed; the master was already answered.
        if (bus_done) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase

    if (fire) begin
      if (gnt_q) begin
        m1_rdata_d = fire_val;
        m1_done_d  = 1'b1;
      end else begin
        m0_rdata_d = fire_val;
        m0_done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      gnt_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      m0_done_q  <= 1'b0;
      m1_done_q  <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      cnt_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      we_q       <= we_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
      m0_done_q  <= m0_done_d;
      m1_done_q  <= m1_done_d;
`ifdef BUS_ARB_TIMEOUT_EN
      cnt_q      <= cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  assign bus_addr  = addr_q;
  assign bus_data  = data_q;
  assign bus_we    = we_q;
  assign bus_start = (state_q == ISSUE);
  assign busy      = (state_q != IDLE);
  assign m0_q      = m0_rdata_q;
  assign m0_done   = m0_done_q;
  assign m1_q      = m1_rdata_q;
  assign m1_done   = m1_done_q;
`ifdef BUS_ARB_TIMEOUT_EN
  assign err_to    = err_q;
`else
  assign err_to    = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for bus_arbiter: stimulus queues expected bus issues and master completions,
// separate monitors pop and compare whenever the DUT presents bus_start or mX_done.
module tb_bus_arbiter;
  localparam int AW = 27;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_data, m1_data;
  logic          m0_we, m1_we, m0_start, m1_start;
  logic [DW-1:0] m0_q, m1_q;
  logic          m0_done, m1_done;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_data;
  logic          bus_we, bus_start;
  logic [DW-1:0] bus_q;
  logic          bus_done;
  logic          busy, err_to;

  always #5 clk = ~clk;

  bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16), .TIMEOUT_Q(32'hDEADBEEF)) dut (
    .clk(clk), .nreset(nreset),
    .m0_addr(m0_addr), .m0_data(m0_data), .m0_we(m0_we), .m0_start(m0_start),
    .m0_q(m0_q), .m0_done(m0_done),
    .m1_addr(m1_addr), .m1_data(m1_data), .m1_we(m1_we), .m1_start(m1_start),
    .m1_q(m1_q), .m1_done(m1_done),
    .bus_addr(bus_addr), .bus_data(bus_data), .bus_we(bus_we), .bus_start(bus_start),
    .bus_q(bus_q), .bus_done(bus_done), .busy(busy), .err_to(err_to)
  );

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; logic we; } bus_t;
  typedef struct { int m; logic [DW-1:0] q; } done_t;
  typedef struct { int dly; logic [DW-1:0] q; } resp_t;

  bus_t  exp_bus[$];
  done_t exp_done[$];
  resp_t resp_q[$];
  int    start_cycs[$];
  int    bdone_cycs[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cyc = 0;
  int done_cyc[2];
  int spur_req = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] resp_val(input logic [AW-1:0] a);
    return 32'hA500_0000 ^ {5'b0, a};
  endfunction

  task automatic check_done(input int m, input logic [DW-1:0] q);
    done_t d;
    if (exp_done.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_done: got m%0d_done q=0x%0h, expected no done", m, q);
    end else begin
      d = exp_done.pop_front();
      check("done_master", m, d.m);
      check("done_q", q, d.q);
    end
  endtask

  // Bus/done monitor: pops the scoreboard whenever the DUT presents something.
  initial begin : monitor
    bus_t          e;
    logic          prev_start;
    logic [59:0]   cap;
    prev_start = 1'b0;
    cap = '0;
    forever begin
      @(negedge clk);
      if (nreset) begin
        if (bus_start) begin
          check("bus_start_pulse", prev_start, 1'b0);
          start_cyc = cyc;
          start_cycs.push_back(cyc);
          cap = {bus_we, bus_data, bus_addr};
          if (exp_bus.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_issue: got bus_start addr=0x%0h, expected none", bus_addr);
          end else begin
            e = exp_bus.pop_front();
            check("bus_addr", bus_addr, e.addr);
            check("bus_data", bus_data, e.data);
            check("bus_we", bus_we, e.we);
          end
        end
        if (bus_done && busy) check("bus_stable", {bus_we, bus_data, bus_addr}, cap);
        if (m0_done && m1_done) check("done_exclusive", 2'b11, 2'b01);
        if (m0_done) begin done_cyc[0] = cyc; check_done(0, m0_q); end
        if (m1_done) begin done_cyc[1] = cyc; check_done(1, m1_q); end
      end
      prev_start = nreset ? bus_start : 1'b0;
    end
  end

  // MemoryUnit model: answers each bus_start after the queued delay with the queued data.
  initial begin : slave
    int    cd;
    resp_t r;
    logic [DW-1:0] rq;
    int    spur_ack;
    cd = 0; rq = '0; spur_ack = 0;
    bus_done = 1'b0;
    bus_q = '0;
    forever begin
      @(negedge clk);
      bus_done = 1'b0;
      if (!nreset) cd = 0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          bus_done = 1'b1;
          bus_q = rq;
          bdone_cycs.push_back(cyc);
        end
      end else if (bus_start && nreset) begin
        if (resp_q.size() > 0) begin
          r = resp_q.pop_front();
          cd = r.dly;
          rq = r.q;
        end else begin
          cd = 1;
          rq = '0;
        end
      end
      if (spur_req != spur_ack) begin
        bus_done = 1'b1;
        bus_q = 32'h5A5A5A5A;
        spur_ack++;
      end
    end
  end

  task automatic m_req(input int m, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w);
    if (m == 0) begin
      m0_addr = a; m0_data = d; m0_we = w; m0_start = 1'b1;
    end else begin
      m1_addr = a; m1_data = d; m1_we = w; m1_start = 1'b1;
    end
  endtask

  task automatic wait_done(input int m, input int max_cyc, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if ((m == 0 && m0_done) || (m == 1 && m1_done)) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, seen, 1'b1);
  endtask

  task automatic wait_busy(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, seen, 1'b1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int r;
    m0_addr = '0; m0_data = '0; m0_we = 1'b0; m0_start = 1'b0;
    m1_addr = '0; m1_data = '0; m1_we = 1'b0; m1_start = 1'b0;
    nreset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {bus_start, busy, m0_done, m1_done, err_to, bus_we}, 6'b0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_data", bus_data, 0);
    check("rst_m_q", {m0_q, m1_q}, 64'h0);
    nreset = 1'b1;
    repeat (2) @(negedge clk);

    // Reset asserted while the transaction sits in WAIT.
    exp_bus.push_back('{addr: 27'h0000200, data: 32'h0, we: 1'b0});
    resp_q.push_back('{dly: 10, q: 32'h77});
    m_req(0, 27'h0000200, 32'h0, 1'b0);
    wait_busy("t1_busy");
    repeat (3) @(negedge clk);
    #2 nreset = 1'b0;
    #1 check("t1_async_reset", {bus_start, m0_done, m1_done, busy}, 4'b0);
    m0_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    check("t1_idle_after_release", busy, 1'b0);

    // Simultaneous requests after reset: strict alternation starting with m0.
    for (int k = 0; k < 4; k++) begin
      exp_bus.push_back('{addr: 27'h10 + 27'(k), data: 32'h0, we: 1'b0});
      exp_bus.push_back('{addr: 27'h20 + 27'(k), data: 32'h0, we: 1'b0});
      exp_done.push_back('{m: 0, q: resp_val(27'h10 + 27'(k))});
      exp_done.push_back('{m: 1, q: resp_val(27'h20 + 27'(k))});
      resp_q.push_back('{dly: 1, q: resp_val(27'h10 + 27'(k))});
      resp_q.push_back('{dly: 2, q: resp_val(27'h20 + 27'(k))});
    end
    fork
      for (int k = 0; k < 4; k++) begin
        m_req(0, 27'h10 + 27'(k), 32'h0, 1'b0);
        wait_done(0, 40, "t3_m0_done");
        m0_start = 1'b0;
        @(negedge clk);
      end
      for (int k = 0; k < 4; k++) begin
        m_req(1, 27'h20 + 27'(k), 32'h0, 1'b0);
        wait_done(1, 40, "t3_m1_done");
        m1_start = 1'b0;
        @(negedge clk);
      end
    join
    repeat (2) @(negedge clk);

    // Single m0 read; check issue and completion latency.
    exp_bus.push_back('{addr: 27'h0000100, data: 32'h0, we: 1'b0});
    exp_done.push_back('{m: 0, q: 32'h12345678});
    resp_q.push_back('{dly: 3, q: 32'h12345678});
    r = cyc;
    m_req(0, 27'h0000100, 32'h0, 1'b0);
    wait_done(0, 20, "t2_m0_done");
    m0_start = 1'b0;
    check("t2_issue_latency", start_cyc - r, 1);
    check("t2_done_latency", done_cyc[0] - start_cyc, 4);
    repeat (2) @(negedge clk);

    // m1 write while m0 idle; m0 read data must stay held.
    exp_bus.push_back('{addr: 27'h4000000, data: 32'hCAFEF00D, we: 1'b1});
    exp_done.push_back('{m: 1, q: 32'h0});
    resp_q.push_back('{dly: 2, q: 32'h0});
    m_req(1, 27'h4000000, 32'hCAFEF00D, 1'b1);
    wait_done(1, 20, "t4_m1_done");
    m1_start = 1'b0;
    check("t4_m0_q_held", m0_q, 32'h12345678);
    repeat (2) @(negedge clk);

    // Spurious bus_done in IDLE, then m0 drops start right after grant.
    spur_req++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_spurious_ignored", {m0_done, m1_done, busy}, 3'b0);
    end
    exp_bus.push_back('{addr: 27'h0000155, data: 32'h0, we: 1'b0});
    exp_done.push_back('{m: 0, q: 32'h0BADF00D});
    resp_q.push_back('{dly: 2, q: 32'h0BADF00D});
    m_req(0, 27'h0000155, 32'h0, 1'b0);
    wait_busy("t5_granted");
    m0_start = 1'b0;
    wait_done(0, 20, "t5_m0_done_after_drop");
    repeat (3) @(negedge clk);

`ifdef BUS_ARB_TIMEOUT_EN
    // Silent slave: watchdog answers m0, m1 waits for the late bus_done.
    start_cycs.delete();
    bdone_cycs.delete();
    exp_bus.push_back('{addr: 27'h00000AB, data: 32'h0, we: 1'b0});
    exp_done.push_back('{m: 0, q: 32'hDEADBEEF});
    resp_q.push_back('{dly: 30, q: 32'h11111111});
    exp_bus.push_back('{addr: 27'h00000CD, data: 32'h0, we: 1'b0});
    exp_done.push_back('{m: 1, q: resp_val(27'h00000CD)});
    resp_q.push_back('{dly: 2, q: resp_val(27'h00000CD)});
    m_req(0, 27'h00000AB, 32'h0, 1'b0);
    wait_busy("t6_busy");
    m_req(1, 27'h00000CD, 32'h0, 1'b0);
    wait_done(0, 30, "t6_m0_timeout_done");
    m0_start = 1'b0;
    check("t6_timeout_latency", done_cyc[0] - start_cyc, 16);
    check("t6_err_to", err_to, 1'b1);
    wait_done(1, 60, "t6_m1_done");
    m1_start = 1'b0;
    repeat (4) @(negedge clk);
    check("t6_issue_count", start_cycs.size(), 2);
    if (start_cycs.size() == 2 && bdone_cycs.size() >= 1)
      check("t6_m1_after_late_done", start_cycs[1] > bdone_cycs[0], 1'b1);
    else
      check("t6_late_done_seen", bdone_cycs.size() >= 1, 1'b1);
`else
    check("err_to_tied_low", err_to, 1'b0);
`endif

    repeat (5) @(negedge clk);
    check("exp_bus_drained", exp_bus.size(), 0);
    check("exp_done_drained", exp_done.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
